// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - control, program-load and instruction-output bundle of the fetch unit
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic               stall;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc_out;
  logic               halted;
  logic               busy;
  logic [15:0]        fetch_count;

  // Sequencer / loader side
  modport master (
    output start, stall, load_en, load_addr, load_data,
    input  instr_out, instr_valid, pc_out, halted, busy, fetch_count
  );

  // Fetch unit side
  modport slave (
    input  start, stall, load_en, load_addr, load_data,
    output instr_out, instr_valid, pc_out, halted, busy, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program memory plus PC that emits one instruction per cycle, with stall and HALT
module instr_fetch_unit #(
  parameter int         ADDR_W      = 8,
  parameter int         DEPTH       = 256,
  parameter int         INSTR_W     = 16,
  parameter logic [2:0] HALT_OPCODE = 3'b111
) (
  input  logic            clk,
  input  logic            reset,
  instr_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] curWord;
  logic               isHalt;
  logic               fetchGo;
  logic               haltGo;
  logic               runStart;
  logic               resumeStart;

  logic [INSTR_W-1:0] instrReg;
  logic               validReg;
  logic [ADDR_W-1:0]  pcOutReg;
  logic               haltedReg;
  logic [15:0]        countReg;

  // The word under the PC is read combinationally and only registered on a fetch edge
  assign curWord = mem[pc];
  assign isHalt  = (curWord[INSTR_W-1 -: 3] == HALT_OPCODE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and per-edge actions; a stalled HALT word stays unconsumed
  always_comb begin
    nextState   = state;
    fetchGo     = 1'b0;
    haltGo      = 1'b0;
    runStart    = 1'b0;
    resumeStart = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = RUN;
          runStart  = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (isHalt) begin
            haltGo    = 1'b1;
            nextState = HALTED;
          end else begin
            fetchGo = 1'b1;
          end
        end
      end
      HALTED: begin
        if (bus.start) begin
          nextState   = RUN;
          resumeStart = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Program load; writes are only accepted while not fetching, and memory is never cleared
  always_ff @(posedge clk) begin
    if (bus.load_en && (state != RUN)) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // PC, output word register and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      instrReg  <= '0;
      validReg  <= 1'b0;
      pcOutReg  <= '0;
      haltedReg <= 1'b0;
      countReg  <= '0;
    end else begin
      validReg <= fetchGo;
      if (runStart) begin
        pc <= '0;
      end
      if (resumeStart) begin
        haltedReg <= 1'b0;
      end
      if (fetchGo) begin
        instrReg <= curWord;
        pcOutReg <= pc;
        pc       <= pc + 1'b1;
        countReg <= countReg + 16'd1;
      end
      if (haltGo) begin
        haltedReg <= 1'b1;
        pc        <= pc + 1'b1;
      end
    end
  end

  assign bus.instr_out   = instrReg;
  assign bus.instr_valid = validReg;
  assign bus.pc_out      = pcOutReg;
  assign bus.halted      = haltedReg;
  assign bus.busy        = (state == RUN);
  assign bus.fetch_count = countReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  instr_fetch_unit #(
    .ADDR_W(8), .DEPTH(256), .INSTR_W(16), .HALT_OPCODE(3'b111)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        stall;
    logic        expValid;
    logic [15:0] expInstr;
    logic [7:0]  expPc;
    logic        expHalted;
    logic        expBusy;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs [15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [15:0] instr,
                          input logic [7:0] pc, input logic h, input logic b, input logic [15:0] cnt);
    check({tag, ".valid"},  32'(bus.instr_valid), 32'(v));
    check({tag, ".instr"},  32'(bus.instr_out),   32'(instr));
    check({tag, ".pc"},     32'(bus.pc_out),      32'(pc));
    check({tag, ".halted"}, 32'(bus.halted),      32'(h));
    check({tag, ".busy"},   32'(bus.busy),        32'(b));
    check({tag, ".count"},  32'(bus.fetch_count), 32'(cnt));
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [15:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic doReset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulseStart;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;

    // rst start stall | valid instr pc halted busy count
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4006, 8'd0, 1'b0, 1'b1, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h40BF, 8'd1, 1'b0, 1'b1, 16'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h8904, 8'd2, 1'b0, 1'b1, 16'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h8904, 8'd2, 1'b1, 1'b0, 16'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h8904, 8'd2, 1'b1, 1'b0, 16'd3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 16'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4006, 8'd0, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h4006, 8'd0, 1'b0, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h4006, 8'd0, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h40BF, 8'd1, 1'b0, 1'b1, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h8904, 8'd2, 1'b0, 1'b1, 16'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8904, 8'd2, 1'b0, 1'b1, 16'd3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h8904, 8'd2, 1'b1, 1'b0, 16'd3};

    tick();
    tick();
    reset = 1'b0;
    checkOut("reset", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 16'd0);

    loadWord(8'd0, 16'h4006);
    loadWord(8'd1, 16'h40BF);
    loadWord(8'd2, 16'h8904);
    loadWord(8'd3, 16'hE000);

    // Basic run, halt, then reset and a run with stalls on a normal word and on the HALT word
    for (int i = 0; i < 15; i++) begin
      reset     = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.stall = vecs[i].stall;
      tick();
      checkOut($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expInstr, vecs[i].expPc,
               vecs[i].expHalted, vecs[i].expBusy, vecs[i].expCount);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;

    // Resume after HALT continues at the following word
    doReset();
    loadWord(8'd1, 16'hE000);
    loadWord(8'd2, 16'h8BBF);
    pulseStart();
    tick();
    checkOut("res.first", 1'b1, 16'h4006, 8'd0, 1'b0, 1'b1, 16'd1);
    tick();
    checkOut("res.halt", 1'b0, 16'h4006, 8'd0, 1'b1, 1'b0, 16'd1);
    pulseStart();
    checkOut("res.edge", 1'b0, 16'h4006, 8'd0, 1'b0, 1'b1, 16'd1);
    tick();
    checkOut("res.word", 1'b1, 16'h8BBF, 8'd2, 1'b0, 1'b1, 16'd2);
    tick();
    checkOut("res.halt2", 1'b0, 16'h8BBF, 8'd2, 1'b1, 1'b0, 16'd2);

    // PC wrap with no HALT word anywhere
    doReset();
    for (int a = 0; a < 256; a++) begin
      loadWord(8'(a), 16'h1000 | 16'(a));
    end
    pulseStart();
    for (int i = 0; i < 258; i++) begin
      tick();
      check($sformatf("wrap%0d.valid", i), 32'(bus.instr_valid), 32'd1);
      check($sformatf("wrap%0d.pc", i),    32'(bus.pc_out),      32'(i % 256));
      check($sformatf("wrap%0d.instr", i), 32'(bus.instr_out),   32'(16'h1000 | 16'(i % 256)));
    end
    check("wrap.count", 32'(bus.fetch_count), 32'd258);
    check("wrap.busy",  32'(bus.busy),        32'd1);

    // Reset while running at pc=5, then restart with memory intact
    doReset();
    pulseStart();
    for (int i = 0; i < 5; i++) tick();
    checkOut("mid.pre", 1'b1, 16'h1004, 8'd4, 1'b0, 1'b1, 16'd5);
    reset = 1'b1;
    tick();
    checkOut("mid.reset", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    pulseStart();
    tick();
    checkOut("mid.restart", 1'b1, 16'h1000, 8'd0, 1'b0, 1'b1, 16'd1);

    // Load during RUN is dropped; load together with start lands before the first fetch
    bus.load_en = 1'b1;
    bus.load_addr = 8'd0;
    bus.load_data = 16'hFFFF;
    tick();
    bus.load_en = 1'b0;
    check("runload.word", 32'(bus.instr_out), 32'h1001);
    doReset();
    pulseStart();
    tick();
    checkOut("runload.ignored", 1'b1, 16'h1000, 8'd0, 1'b0, 1'b1, 16'd1);
    doReset();
    bus.load_en = 1'b1;
    bus.load_addr = 8'd0;
    bus.load_data = 16'h20D0;
    bus.start = 1'b1;
    tick();
    bus.load_en = 1'b0;
    bus.start = 1'b0;
    checkOut("ldstart.edge", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1, 16'd0);
    tick();
    checkOut("ldstart.first", 1'b1, 16'h20D0, 8'd0, 1'b0, 1'b1, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
